// File: rtl/game_tick_timer_if.sv
// Control and status bundle for game_tick_timer: the controller drives timing
// requests, and the timer returns tick, count, phase and state flags.
interface game_tick_timer_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 start;
    logic                 stop;
    logic                 pause;
    logic                 mode;
    logic [WIDTH-1:0]     period;
    logic [WIDTH-1:0]     period_fast;
    logic                 fast;
    logic                 clr_count;
    logic                 tick;
    logic [CNT_WIDTH-1:0] count;
    logic [WIDTH-1:0]     phase;
    logic                 busy;
    logic                 done;

    modport master (
        output start, stop, pause, mode, period, period_fast, fast, clr_count,
        input  tick, count, phase, busy, done
    );

    modport slave (
        input  start, stop, pause, mode, period, period_fast, fast, clr_count,
        output tick, count, phase, busy, done
    );
endinterface

// File: rtl/game_tick_timer.sv
// Prescaled game tick generator with periodic/one-shot modes, pause, a fast
// (soft drop) period and a wrapping or saturating tick counter.
module game_tick_timer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 32,
    parameter bit          SATURATE  = 1'b0
) (
    input logic              clk,
    input logic              rst,
    game_tick_timer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t               state_q, state_n;
    logic [WIDTH-1:0]     phase_q, phase_n;
    logic [WIDTH-1:0]     p_act_q, p_act_n;
    logic [CNT_WIDTH-1:0] count_q, count_n;
    logic                 tick_q, tick_n;
    logic                 mode_q, mode_n;
    logic                 busy_q, busy_n;
    logic                 done_q, done_n;
    logic                 complete;
    logic [WIDTH-1:0]     p_sel;
    logic [CNT_WIDTH-1:0] count_inc;

    // Period chosen at every latch point (start or completion).
    assign p_sel     = bus.fast ? bus.period_fast : bus.period;
    assign count_inc = (SATURATE && (count_q == CNT_MAX)) ? count_q
                                                          : count_q + CNT_WIDTH'(1);

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            p_act_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            phase_q <= phase_n;
            p_act_q <= p_act_n;
            count_q <= count_n;
            tick_q  <= tick_n;
            mode_q  <= mode_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Next state and datapath; stop beats start, start beats period completion.
    always_comb begin
        state_n  = state_q;
        phase_n  = phase_q;
        p_act_n  = p_act_q;
        mode_n   = mode_q;
        tick_n   = 1'b0;
        complete = 1'b0;

        if (bus.stop) begin
            state_n = ST_IDLE;
            phase_n = '0;
        end else if (bus.start) begin
            phase_n = '0;
            p_act_n = p_sel;
            mode_n  = bus.mode;
            state_n = bus.pause ? ST_PAUSED : ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.pause) begin
                        state_n = ST_PAUSED;
                    end else if (phase_q == p_act_q) begin
                        complete = 1'b1;
                        phase_n  = '0;
                        tick_n   = 1'b1;
                        p_act_n  = p_sel;
                        state_n  = mode_q ? ST_DONE : ST_RUN;
                    end else begin
                        phase_n = phase_q + WIDTH'(1);
                    end
                end
                ST_PAUSED: begin
                    if (!bus.pause) begin
                        state_n = ST_RUN;
                    end
                end
                default: begin
                    state_n = state_q;
                end
            endcase
        end

        // Clear wins over the increment, but a coincident completion still counts once.
        if (bus.clr_count) begin
            count_n = complete ? CNT_WIDTH'(1) : '0;
        end else if (complete) begin
            count_n = count_inc;
        end else begin
            count_n = count_q;
        end

        busy_n = (state_n == ST_RUN) || (state_n == ST_PAUSED);
        done_n = (state_n == ST_DONE);
    end

    assign bus.tick  = tick_q;
    assign bus.count = count_q;
    assign bus.phase = phase_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_game_tick_timer.sv
// Self-checking bench for game_tick_timer: directed scenarios plus random
// stimulus, every cycle compared against a behavioural model of the timer.
module tb_game_tick_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, pause, mode, fast, clr_count;
    logic [31:0] period, period_fast;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    game_tick_timer_if #(.WIDTH(32), .CNT_WIDTH(32)) if0 ();
    game_tick_timer_if #(.WIDTH(8),  .CNT_WIDTH(3))  if1 ();
    game_tick_timer_if #(.WIDTH(8),  .CNT_WIDTH(3))  if2 ();

    game_tick_timer #(.WIDTH(32), .CNT_WIDTH(32), .SATURATE(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    game_tick_timer #(.WIDTH(8),  .CNT_WIDTH(3),  .SATURATE(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    game_tick_timer #(.WIDTH(8),  .CNT_WIDTH(3),  .SATURATE(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.start = start;  assign if1.start = start;  assign if2.start = start;
    assign if0.stop  = stop;   assign if1.stop  = stop;   assign if2.stop  = stop;
    assign if0.pause = pause;  assign if1.pause = pause;  assign if2.pause = pause;
    assign if0.mode  = mode;   assign if1.mode  = mode;   assign if2.mode  = mode;
    assign if0.fast  = fast;   assign if1.fast  = fast;   assign if2.fast  = fast;
    assign if0.clr_count = clr_count;
    assign if1.clr_count = clr_count;
    assign if2.clr_count = clr_count;
    assign if0.period      = period;
    assign if1.period      = period[7:0];
    assign if2.period      = period[7:0];
    assign if0.period_fast = period_fast;
    assign if1.period_fast = period_fast[7:0];
    assign if2.period_fast = period_fast[7:0];

    // Timer seen as: active (running or frozen), frozen, finished, plus counters.
    typedef struct {
        bit     active;
        bit     frozen;
        bit     finished;
        bit     oneshot;
        bit     tick;
        longint phase;
        longint target;
        longint count;
    } mdl_t;

    mdl_t m0, m1, m2;

    function automatic mdl_t mstep(mdl_t m, int cw, bit sat);
        mdl_t   n    = m;
        bit     fin  = 1'b0;
        longint top  = (longint'(1) << cw) - 1;
        longint want = fast ? longint'(period_fast) : longint'(period);
        if (cw == 32) begin
            want = want & 64'hFFFF_FFFF;
        end else begin
            want = want & 64'hFF;
        end
        n.tick = 1'b0;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        if (stop) begin
            n.active = 1'b0; n.frozen = 1'b0; n.finished = 1'b0; n.phase = 0;
        end else if (start) begin
            n.phase = 0; n.target = want; n.oneshot = mode;
            n.active = 1'b1; n.frozen = pause; n.finished = 1'b0;
        end else if (m.active && !m.frozen) begin
            if (pause) begin
                n.frozen = 1'b1;
            end else if (m.phase == m.target) begin
                fin = 1'b1; n.phase = 0; n.tick = 1'b1; n.target = want;
                if (m.oneshot) begin
                    n.active = 1'b0; n.finished = 1'b1;
                end
            end else begin
                n.phase = m.phase + 1;
            end
        end else if (m.frozen && !pause) begin
            n.frozen = 1'b0;
        end
        if (fin) n.count = (sat && m.count == top) ? top : ((m.count + 1) & top);
        if (clr_count) n.count = fin ? 1 : 0;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string pfx, input logic t, input logic [63:0] c,
                           input logic [63:0] p, input logic b, input logic d, input mdl_t m);
        chk({pfx, ".tick"},  64'(t), 64'(m.tick));
        chk({pfx, ".count"}, c, m.count);
        chk({pfx, ".phase"}, p, m.phase);
        chk({pfx, ".busy"},  64'(b), 64'(m.active));
        chk({pfx, ".done"},  64'(d), 64'(m.finished));
    endtask

    // One clock edge: advance the models with the inputs just sampled, then compare.
    task automatic cyc();
        @(posedge clk);
        m0 = mstep(m0, 32, 1'b0);
        m1 = mstep(m1, 3, 1'b0);
        m2 = mstep(m2, 3, 1'b1);
        #1;
        chk_all("u0", if0.tick, 64'(if0.count), 64'(if0.phase), if0.busy, if0.done, m0);
        chk_all("u1", if1.tick, 64'(if1.count), 64'(if1.phase), if1.busy, if1.done, m1);
        chk_all("u2", if2.tick, 64'(if2.count), 64'(if2.phase), if2.busy, if2.done, m2);
    endtask

    // Edges until u0 ticks, bounded.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (if0.tick !== 1'b1 && n < 200);
        if (if0.tick !== 1'b1) chk("tick_timeout", 64'(if0.tick), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    initial begin
        int n;
        m0 = '{default: 0}; m1 = '{default: 0}; m2 = '{default: 0};
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0;
        fast = 1'b0; clr_count = 1'b0; period = 32'd0; period_fast = 32'd0;
        cyc(); cyc();
        chk("rst_count", 64'(if0.count), 64'd0);
        chk("rst_busy",  64'(if0.busy),  64'd0);
        chk("rst_done",  64'(if0.done),  64'd0);
        rst = 1'b0;

        // Periodic, P=3: a tick every 4 edges, landing in the 5th/9th/13th cycle.
        period = 32'd3; pulse_start();
        for (int k = 1; k <= 3; k++) begin
            wait_tick(n);
            chk("periodic_gap", 64'(n), 64'd4);
            chk("periodic_count", 64'(if0.count), 64'(k));
        end
        pulse_stop();

        // One-shot, P=2, counter cleared by the same start.
        mode = 1'b1; period = 32'd2; clr_count = 1'b1; pulse_start(); clr_count = 1'b0;
        mode = 1'b0;
        wait_tick(n);
        chk("oneshot_first", 64'(n), 64'd3);
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("oneshot_tick", 64'(if0.tick), 64'd0);
            chk("oneshot_count", 64'(if0.count), 64'd1);
            chk("oneshot_done", 64'(if0.done), 64'd1);
        end
        pulse_stop();

        // Fast raised mid-period only takes effect at the next latch point.
        period = 32'd9; period_fast = 32'd1; pulse_start();
        cyc(); cyc(); cyc();
        fast = 1'b1;
        wait_tick(n);
        chk("fast_first", 64'(n + 3), 64'd10);
        wait_tick(n); chk("fast_gap1", 64'(n), 64'd2);
        wait_tick(n); chk("fast_gap2", 64'(n), 64'd2);
        fast = 1'b0; pulse_stop();

        // Pause at phase 2: frozen six cycles including the resume edge.
        period = 32'd4; pulse_start();
        cyc(); cyc();
        chk("pause_phase_entry", 64'(if0.phase), 64'd2);
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("pause_phase", 64'(if0.phase), 64'd2);
            chk("pause_tick", 64'(if0.tick), 64'd0);
        end
        pause = 1'b0; cyc();
        chk("pause_resume_phase", 64'(if0.phase), 64'd2);
        wait_tick(n);
        chk("pause_first_tick", 64'(8 + n), 64'd11);
        pulse_stop();

        // P=0 ticks every cycle: 3-bit counters wrap or saturate after 10 ticks.
        clr_count = 1'b1; cyc(); clr_count = 1'b0;
        period = 32'd0; pulse_start();
        repeat (10) cyc();
        chk("wrap_count", 64'(if1.count), 64'd2);
        chk("sat_count",  64'(if2.count), 64'd7);
        clr_count = 1'b1; cyc(); clr_count = 1'b0;
        chk("wrap_clr_tick", 64'(if1.count), 64'd1);
        chk("sat_clr_tick",  64'(if2.count), 64'd1);
        pulse_stop();

        // Reset overrides start mid-period; stop beats start; restart zeroes phase.
        period = 32'd7; pulse_start();
        repeat (5) cyc();
        chk("prio_phase5", 64'(if0.phase), 64'd5);
        rst = 1'b1; start = 1'b1; clr_count = 1'b1; cyc();
        rst = 1'b0; start = 1'b0; clr_count = 1'b0;
        chk("prio_rst_phase", 64'(if0.phase), 64'd0);
        chk("prio_rst_count", 64'(if0.count), 64'd0);
        chk("prio_rst_busy",  64'(if0.busy),  64'd0);
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk("prio_stop_busy", 64'(if0.busy), 64'd0);
        pulse_start();
        repeat (3) cyc();
        pulse_start();
        chk("restart_phase", 64'(if0.phase), 64'd0);
        chk("restart_tick",  64'(if0.tick),  64'd0);
        chk("restart_busy",  64'(if0.busy),  64'd1);

        // Random traffic, including period changes between latch points.
        for (int k = 0; k < 3000; k++) begin
            rst         = ($urandom_range(99) == 0);
            stop        = ($urandom_range(29) == 0);
            start       = ($urandom_range(14) == 0);
            clr_count   = ($urandom_range(39) == 0);
            mode        = 1'($urandom_range(1));
            period      = 32'($urandom_range(7));
            period_fast = 32'($urandom_range(3));
            if ($urandom_range(7) == 0) pause = ~pause;
            if ($urandom_range(9) == 0) fast = ~fast;
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
